// File: rtl/gcd_stein_if.sv
// Handshake bundle for the binary GCD engine: operand channel (in_*, x, y)
// and result channel (out_*, o, zero, steps).
interface gcd_stein_if #(
  parameter int WIDTH = 16,
  parameter int STEPW = $clog2(2*WIDTH)+1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             zero;
  logic [STEPW-1:0] steps;

  // Requester side: supplies operands and consumes results.
  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, o, zero, steps
  );

  // Engine side.
  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, o, zero, steps
  );
endinterface

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine. Accepts an operand pair in IDLE, iterates one
// reduction step per RUN cycle and presents gcd, a both-zero flag and the
// number of RUN cycles used until the result is taken.
module gcd_stein #(
  parameter int WIDTH = 16,
  parameter int STEPW = $clog2(2*WIDTH)+1
) (
  input logic        clk,
  input logic        rst,
  gcd_stein_if.slave bus
);

  // Shift count only ever reaches log2(min(x, y)), so this width is ample.
  localparam int KW = $clog2(WIDTH)+1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] o_reg, o_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [STEPW-1:0] steps_reg, steps_next;
  logic             zero_reg, zero_next;

  logic             a_even, b_even, a_eq_b, a_gt_b;
  logic             x_is_zero, y_is_zero;

  assign a_even    = ~a_reg[0];
  assign b_even    = ~b_reg[0];
  assign a_eq_b    = (a_reg == b_reg);
  assign a_gt_b    = (a_reg > b_reg);
  assign x_is_zero = (bus.x == '0);
  assign y_is_zero = (bus.y == '0);

  // Handshake flags decode straight from the state register; the result
  // fields come from their own registers, so nothing depends on out_ready
  // combinationally.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.o         = o_reg;
  assign bus.zero      = zero_reg;
  assign bus.steps     = steps_reg;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      k_reg     <= '0;
      steps_reg <= '0;
      zero_reg  <= 1'b0;
      o_reg     <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      k_reg     <= k_next;
      steps_reg <= steps_next;
      zero_reg  <= zero_next;
      o_reg     <= o_next;
    end
  end

  // Next-state and datapath: accept in IDLE, one Stein reduction per RUN
  // cycle (first matching rule wins), hold the result in DONE.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    k_next     = k_reg;
    steps_next = steps_reg;
    zero_next  = zero_reg;
    o_next     = o_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.x;
          b_next     = bus.y;
          k_next     = '0;
          steps_next = '0;
          if (x_is_zero || y_is_zero) begin
            // gcd(0, n) = n; the OR picks the nonzero one (or 0 for both).
            o_next     = bus.x | bus.y;
            zero_next  = x_is_zero && y_is_zero;
            state_next = DONE;
          end else begin
            zero_next  = 1'b0;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        steps_next = steps_reg + STEPW'(1);
        if (a_eq_b) begin
          // Restore the common power of two stripped off earlier.
          o_next     = a_reg << k_reg;
          state_next = DONE;
        end else if (a_even && b_even) begin
          a_next = a_reg >> 1;
          b_next = b_reg >> 1;
          k_next = k_reg + KW'(1);
        end else if (a_even) begin
          a_next = a_reg >> 1;
        end else if (b_even) begin
          b_next = b_reg >> 1;
        end else if (a_gt_b) begin
          // Both odd and unequal: the difference is even and nonzero, so
          // halving it immediately is exact.
          a_next = (a_reg - b_reg) >> 1;
        end else begin
          b_next = (b_reg - a_reg) >> 1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed and randomised checks of gcd_stein at WIDTH 16, 8 and 32.
module tb_gcd_stein;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gcd_stein_if #(.WIDTH(16)) if16 ();
  gcd_stein_if #(.WIDTH(8))  if8  ();
  gcd_stein_if #(.WIDTH(32)) if32 ();

  gcd_stein #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
  gcd_stein #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  gcd_stein #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] exp_o;
    logic        exp_zero;
    int          exp_steps;
  } vec_t;

  vec_t vecs [10];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(int w, logic v, logic [31:0] xv, logic [31:0] yv);
    case (w)
      8:  begin if8.in_valid  = v; if8.x  = xv[7:0];  if8.y  = yv[7:0];  end
      16: begin if16.in_valid = v; if16.x = xv[15:0]; if16.y = yv[15:0]; end
      default: begin if32.in_valid = v; if32.x = xv; if32.y = yv; end
    endcase
  endtask

  task automatic set_ordy(int w, logic r);
    case (w)
      8:       if8.out_ready  = r;
      16:      if16.out_ready = r;
      default: if32.out_ready = r;
    endcase
  endtask

  function automatic logic get_iready(int w);
    case (w)
      8:       return if8.in_ready;
      16:      return if16.in_ready;
      default: return if32.in_ready;
    endcase
  endfunction

  function automatic logic get_ovalid(int w);
    case (w)
      8:       return if8.out_valid;
      16:      return if16.out_valid;
      default: return if32.out_valid;
    endcase
  endfunction

  function automatic logic get_zero(int w);
    case (w)
      8:       return if8.zero;
      16:      return if16.zero;
      default: return if32.zero;
    endcase
  endfunction

  function automatic logic [31:0] get_o(int w);
    case (w)
      8:       return 32'(if8.o);
      16:      return 32'(if16.o);
      default: return if32.o;
    endcase
  endfunction

  function automatic int get_steps(int w);
    case (w)
      8:       return int'(if8.steps);
      16:      return int'(if16.steps);
      default: return int'(if32.steps);
    endcase
  endfunction

  function automatic logic [31:0] euclid(logic [31:0] a, logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Called at a negedge. Presents operands, waits for the accept edge, then
  // counts edges (accept edge included) until out_valid is seen.
  task automatic start(int w, logic [31:0] xv, logic [31:0] yv, output int lat);
    int guard = 0;
    set_in(w, 1'b1, xv, yv);
    while (!get_iready(w) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_ready", get_iready(w), 1);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, 32'd0, 32'd0);
    lat = 1;
    while (!get_ovalid(w) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", get_ovalid(w), 1);
  endtask

  // Called at a negedge with out_valid high; takes the result.
  task automatic consume(int w);
    set_ordy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(w, 1'b0);
    check("in_ready_after_take", get_iready(w), 1);
    check("out_valid_after_take", get_ovalid(w), 0);
  endtask

  initial begin
    int lat;
    logic [31:0] xv, yv, ev, mask;
    int w;

    vecs[0] = '{16'd12,    16'd18, 16'd6,  1'b0, 4};
    vecs[1] = '{16'd48,    16'd36, 16'd12, 1'b0, 6};
    vecs[2] = '{16'd7,     16'd7,  16'd7,  1'b0, 1};
    vecs[3] = '{16'd0,     16'd5,  16'd5,  1'b0, 0};
    vecs[4] = '{16'd0,     16'd0,  16'd0,  1'b1, 0};
    vecs[5] = '{16'd65535, 16'd1,  16'd1,  1'b0, 16};
    vecs[6] = '{16'd5,     16'd0,  16'd5,  1'b0, 0};
    vecs[7] = '{16'd9,     16'd6,  16'd3,  1'b0, 3};
    vecs[8] = '{16'd1,     16'd1,  16'd1,  1'b0, 1};
    vecs[9] = '{16'd2,     16'd4,  16'd2,  1'b0, 3};

    rst = 1'b1;
    set_in(8, 0, 0, 0);  set_ordy(8, 0);
    set_in(16, 0, 0, 0); set_ordy(16, 0);
    set_in(32, 0, 0, 0); set_ordy(32, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", if16.in_ready, 1);
    check("rst_out_valid", if16.out_valid, 0);
    check("rst_o", if16.o, 0);
    check("rst_zero", if16.zero, 0);
    check("rst_steps", if16.steps, 0);

    // Directed table at WIDTH=16
    for (int i = 0; i < 10; i++) begin
      start(16, 32'(vecs[i].x), 32'(vecs[i].y), lat);
      $display("op w=16 x=%0d y=%0d -> o=%0d zero=%0d steps=%0d lat=%0d",
               vecs[i].x, vecs[i].y, if16.o, if16.zero, if16.steps, lat);
      check("vec_o", if16.o, vecs[i].exp_o);
      check("vec_zero", if16.zero, vecs[i].exp_zero);
      check("vec_steps", if16.steps, vecs[i].exp_steps);
      check("vec_latency", lat, vecs[i].exp_steps + 1);
      consume(16);
    end

    // Result held for 10 cycles under back-pressure; in_valid pulses ignored.
    start(16, 32'd65535, 32'd1, lat);
    $display("op w=16 x=65535 y=1 stalled -> o=%0d steps=%0d", if16.o, if16.steps);
    for (int i = 0; i < 10; i++) begin
      set_in(16, logic'(i % 2), 32'(i * 3 + 4), 32'(i + 2));
      @(negedge clk);
      check("stall_out_valid", if16.out_valid, 1);
      check("stall_o", if16.o, 1);
      check("stall_steps", if16.steps, 16);
      check("stall_in_ready", if16.in_ready, 0);
    end
    set_in(16, 0, 0, 0);
    consume(16);
    @(negedge clk);
    check("stall_no_ghost_accept", if16.in_ready, 1);

    // out_ready held high: no accept on the consume edge, accept on the next.
    start(16, 32'd12, 32'd18, lat);
    check("b2b_first_o", if16.o, 6);
    set_ordy(16, 1'b1);
    set_in(16, 1'b1, 32'd7, 32'd7);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_in_ready", if16.in_ready, 1);
    check("b2b_idle_out_valid", if16.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_accepted", if16.in_ready, 0);
    set_in(16, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_out_valid", if16.out_valid, 1);
    check("b2b_o", if16.o, 7);
    check("b2b_steps", if16.steps, 1);
    $display("op w=16 x=7 y=7 back-to-back -> o=%0d steps=%0d", if16.o, if16.steps);
    @(posedge clk);
    @(negedge clk);
    check("b2b_in_ready_return", if16.in_ready, 1);
    set_ordy(16, 1'b0);

    // Reset in the middle of RUN
    set_in(16, 1'b1, 32'd48, 32'd36);
    @(posedge clk);
    @(negedge clk);
    set_in(16, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_run", if16.in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", if16.out_valid, 0);
    check("midrst_in_ready", if16.in_ready, 1);
    check("midrst_o", if16.o, 0);
    start(16, 32'd9, 32'd6, lat);
    $display("op w=16 x=9 y=6 after reset -> o=%0d steps=%0d", if16.o, if16.steps);
    check("midrst_next_o", if16.o, 3);
    check("midrst_next_steps", if16.steps, 3);
    consume(16);

    // Random regression against a Euclid reference at WIDTH 8 and 32
    for (int pass = 0; pass < 2; pass++) begin
      w    = (pass == 0) ? 8 : 32;
      mask = (pass == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
      for (int i = 0; i < 30; i++) begin
        xv = $urandom() & mask;
        yv = $urandom() & mask;
        if (i % 10 == 3) xv = 32'd0;
        if (i % 10 == 7) yv = yv & 32'h0000_00F0;
        ev = euclid(xv, yv);
        start(w, xv, yv, lat);
        $display("op w=%0d x=%0d y=%0d -> o=%0d zero=%0d steps=%0d",
                 w, xv, yv, get_o(w), get_zero(w), get_steps(w));
        check("rand_o", get_o(w), ev);
        check("rand_zero", get_zero(w), (xv == 0 && yv == 0));
        check("rand_steps_bound", (get_steps(w) <= 2 * w), 1);
        consume(w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
